// File: rtl/hash_cmd_sequencer.sv
// rtl/hash_cmd_sequencer.sv - command-stream sequencer for the hash core handshake
// Decodes 32-bit command words, drives core strobes, enforces ack timeouts and latches the first failure.

module hash_cmd_sequencer #(
   parameter int              IO_W     = 16,
   parameter int              WORD_W   = 32,
   parameter logic [IO_W-1:0] CMP_MASK = {IO_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cmd_valid,
   input  logic [WORD_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic              core_rst,
   output logic              init,
   output logic              load,
   output logic              fetch,
   output logic              getconfig,
   output logic [IO_W-1:0]   idata,
   input  logic              ack,
   input  logic [IO_W-1:0]   odata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code,
   output logic [WORD_W-1:0] fail_index,
   output logic [IO_W-1:0]   fail_data,
   output logic [WORD_W-1:0] cycle_count
);

   localparam logic [WORD_W-1:0] OP_RESET     = WORD_W'(1);
   localparam logic [WORD_W-1:0] OP_CLOCK     = WORD_W'(2);
   localparam logic [WORD_W-1:0] OP_INIT      = WORD_W'(3);
   localparam logic [WORD_W-1:0] OP_GETCONFIG = WORD_W'(4);
   localparam logic [WORD_W-1:0] OP_WAITFOR   = WORD_W'(5);
   localparam logic [WORD_W-1:0] OP_LOAD      = WORD_W'(6);
   localparam logic [WORD_W-1:0] OP_FETCH     = WORD_W'(7);
   localparam logic [WORD_W-1:0] OP_END       = {WORD_W{1'b1}};

   typedef enum logic [2:0] {S_IDLE, S_OPC, S_ARG, S_EXEC, S_DONE, S_ERROR} state_t;

   state_t            state, state_next;
   logic [2:0]        err_code_next;
   logic [WORD_W-1:0] op, a0, a1, a2, cnt, cmd_index;
   logic [WORD_W:0]   cnt_p1;
   logic [1:0]        arg_idx;
   logic              hold_load, hold_fetch;
   logic              last_arg, wait_hit, cmp_ok, restart, cmd_complete;

   function automatic logic [1:0] num_args(input logic [WORD_W-1:0] w);
      case (w)
         OP_RESET, OP_CLOCK, OP_WAITFOR: num_args = 2'd1;
         OP_GETCONFIG:                   num_args = 2'd2;
         OP_LOAD, OP_FETCH:              num_args = 2'd3;
         default:                        num_args = 2'd0;
      endcase
   endfunction

   function automatic logic is_legal(input logic [WORD_W-1:0] w);
      case (w)
         OP_RESET, OP_CLOCK, OP_INIT, OP_GETCONFIG,
         OP_WAITFOR, OP_LOAD, OP_FETCH, OP_END: is_legal = 1'b1;
         default:                               is_legal = 1'b0;
      endcase
   endfunction

   assign cnt_p1       = {1'b0, cnt} + (WORD_W+1)'(1);
   assign last_arg     = (arg_idx == num_args(op) - 2'd1);
   assign wait_hit     = (cnt_p1[WORD_W-1:0] == a1);
   assign cmp_ok       = ((odata & CMP_MASK) == (a0[IO_W-1:0] & CMP_MASK));
   assign restart      = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign cmd_complete = (state_next == S_OPC) && (state == S_EXEC || state == S_ARG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      err_code_next = 3'd0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_OPC;
         S_OPC: if (cmd_valid) begin
            if (!is_legal(cmd_data)) begin
               state_next    = S_ERROR;
               err_code_next = 3'd4;
            end else if (cmd_data == OP_END)      state_next = S_DONE;
            else if (num_args(cmd_data) == 2'd0)  state_next = S_EXEC;
            else                                  state_next = S_ARG;
         end
         S_ARG: if (cmd_valid && last_arg) begin
            // CLOCK and zero-length WAITFOR have nothing to execute
            if (op == OP_CLOCK || (op == OP_WAITFOR && cmd_data == '0)) state_next = S_OPC;
            else                                                         state_next = S_EXEC;
         end
         S_EXEC: case (op)
            OP_RESET, OP_WAITFOR: if (cnt_p1 >= {1'b0, a0}) state_next = S_OPC;
            OP_LOAD: begin
               if (ack) state_next = S_OPC;
               else if (wait_hit) begin
                  state_next    = S_ERROR;
                  err_code_next = 3'd1;
               end
            end
            OP_FETCH, OP_GETCONFIG: begin
               if (ack) begin
                  if (cmp_ok) state_next = S_OPC;
                  else begin
                     state_next    = S_ERROR;
                     err_code_next = 3'd3;
                  end
               end else if (wait_hit) begin
                  state_next    = S_ERROR;
                  err_code_next = 3'd2;
               end
            end
            default: state_next = S_OPC;
         endcase
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == S_OPC) || (state == S_ARG) || (state == S_EXEC);
      cmd_ready = (state == S_OPC) || (state == S_ARG);
      core_rst  = (state == S_EXEC) && (op == OP_RESET);
      init      = (state == S_EXEC) && (op == OP_INIT);
      getconfig = (state == S_EXEC) && (op == OP_GETCONFIG);
      load      = (state == S_EXEC) ? (op == OP_LOAD)
                                    : ((state == S_OPC || state == S_ARG) && hold_load);
      fetch     = (state == S_EXEC) ? (op == OP_FETCH)
                                    : ((state == S_OPC || state == S_ARG) && hold_fetch);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op          <= '0;
         a0          <= '0;
         a1          <= '0;
         a2          <= '0;
         cnt         <= '0;
         arg_idx     <= '0;
         cmd_index   <= '0;
         hold_load   <= 1'b0;
         hold_fetch  <= 1'b0;
         idata       <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= '0;
         fail_index  <= '0;
         fail_data   <= '0;
         cycle_count <= '0;
      end else if (restart) begin
         arg_idx     <= '0;
         cmd_index   <= '0;
         hold_load   <= 1'b0;
         hold_fetch  <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= '0;
         fail_index  <= '0;
         fail_data   <= '0;
         cycle_count <= '0;
      end else begin
         if (busy && cycle_count != {WORD_W{1'b1}}) cycle_count <= cycle_count + WORD_W'(1);
         case (state)
            S_OPC: if (cmd_valid) begin
               op      <= cmd_data;
               arg_idx <= '0;
               cnt     <= '0;
            end
            S_ARG: if (cmd_valid) begin
               case (arg_idx)
                  2'd0:    a0 <= cmd_data;
                  2'd1:    a1 <= cmd_data;
                  default: a2 <= cmd_data;
               endcase
               arg_idx <= arg_idx + 2'd1;
               cnt     <= '0;
               if (last_arg && op == OP_LOAD) idata <= a0[IO_W-1:0];
            end
            S_EXEC: begin
               cnt <= cnt + WORD_W'(1);
               // a hold survives only while the same opcode keeps re-entering EXEC
               if (op == OP_LOAD) begin
                  if (ack) hold_load <= (a2 != '0);
               end else hold_load <= 1'b0;
               if (op == OP_FETCH) begin
                  if (ack) hold_fetch <= (a2 != '0);
               end else hold_fetch <= 1'b0;
            end
            default: ;
         endcase
         if (cmd_complete) cmd_index <= cmd_index + WORD_W'(1);
         if (state_next == S_ERROR && state != S_ERROR) begin
            err        <= 1'b1;
            err_code   <= err_code_next;
            fail_index <= cmd_index;
            if (err_code_next == 3'd3) fail_data <= odata;
            hold_load  <= 1'b0;
            hold_fetch <= 1'b0;
         end
         if (state_next == S_DONE && state != S_DONE) begin
            done       <= 1'b1;
            hold_load  <= 1'b0;
            hold_fetch <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hash_cmd_sequencer.sv
// tb/tb_hash_cmd_sequencer.sv - directed self-checking bench for hash_cmd_sequencer
// A second instance with CMP_MASK=0xFFFE shares all inputs for the masked-compare case.

module tb_hash_cmd_sequencer;
   localparam logic [31:0] OP_RESET = 32'd1, OP_CLOCK = 32'd2, OP_INIT = 32'd3;
   localparam logic [31:0] OP_LOAD = 32'd6, OP_FETCH = 32'd7, OP_END = 32'hFFFF_FFFF;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cmd_valid = 1'b0, ack = 1'b0;
   logic [31:0] cmd_data = '0;
   logic [15:0] odata = '0;

   logic        cmd_ready, core_rst, init, load, fetch, getconfig, busy, done, err;
   logic [15:0] idata, fail_data;
   logic [2:0]  err_code;
   logic [31:0] fail_index, cycle_count;

   logic        m_cmd_ready, m_core_rst, m_init, m_load, m_fetch, m_getconfig, m_busy, m_done, m_err;
   logic [15:0] m_idata, m_fail_data;
   logic [2:0]  m_err_code;
   logic [31:0] m_fail_index, m_cycle_count;

   int errors = 0, checks = 0;
   int rst_hi = 0, init_hi = 0, load_hi = 0, load_lo = 0;

   hash_cmd_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(cmd_ready), .core_rst(core_rst), .init(init), .load(load), .fetch(fetch),
      .getconfig(getconfig), .idata(idata), .ack(ack), .odata(odata), .busy(busy),
      .done(done), .err(err), .err_code(err_code), .fail_index(fail_index),
      .fail_data(fail_data), .cycle_count(cycle_count)
   );

   hash_cmd_sequencer #(.CMP_MASK(16'hFFFE)) dut_m (
      .clk(clk), .rst(rst), .start(start), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(m_cmd_ready), .core_rst(m_core_rst), .init(m_init), .load(m_load), .fetch(m_fetch),
      .getconfig(m_getconfig), .idata(m_idata), .ack(ack), .odata(odata), .busy(m_busy),
      .done(m_done), .err(m_err), .err_code(m_err_code), .fail_index(m_fail_index),
      .fail_data(m_fail_data), .cycle_count(m_cycle_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (core_rst) rst_hi++;
      if (init) init_hi++;
      if (load) load_hi++;
      else load_lo++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_data  = w;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      checks++;
      if (!cmd_ready) begin
         errors++;
         $display("FAIL send_word timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
      end else tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
      checks++; if ({core_rst, init, load, fetch, getconfig} !== 5'b0) begin errors++; $display("FAIL rst_strobes: got %b want 00000", {core_rst, init, load, fetch, getconfig}); end
      checks++; if ({done, err, err_code} !== 5'b0) begin errors++; $display("FAIL rst_status: got %b want 00000", {done, err, err_code}); end
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle_count: got %0d want 0", cycle_count); end
      checks++; if (idata !== 16'd0) begin errors++; $display("FAIL rst_idata: got %h want 0000", idata); end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset_init();
      int r0, i0;
      r0 = rst_hi;
      i0 = init_hi;
      pulse_start();
      send_word(OP_RESET);
      send_word(32'd2);
      send_word(OP_INIT);
      send_word(OP_END);
      @(negedge clk);
      checks++; if (rst_hi - r0 != 2) begin errors++; $display("FAIL ri_core_rst_cycles: got %0d want 2", rst_hi - r0); end
      checks++; if (init_hi - i0 != 1) begin errors++; $display("FAIL ri_init_cycles: got %0d want 1", init_hi - i0); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ri_done: got %0b want 1", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ri_err: got %0b want 0", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ri_busy: got %0b want 0", busy); end
      checks++; if (cycle_count !== 32'd7) begin errors++; $display("FAIL ri_cycle_count: got %0d want 7", cycle_count); end
   endtask

   task automatic test_load();
      int l0;
      l0 = load_hi;
      pulse_start();
      send_word(OP_LOAD);
      send_word(32'h0000_1234);
      send_word(32'd5);
      send_word(32'd0);
      checks++; if (idata !== 16'h1234) begin errors++; $display("FAIL ld_idata: got %h want 1234", idata); end
      checks++; if (load !== 1'b1) begin errors++; $display("FAIL ld_first_cycle: got %0b want 1", load); end
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (load !== 1'b0) begin errors++; $display("FAIL ld_drop: got %0b want 0", load); end
      checks++; if (load_hi - l0 != 3) begin errors++; $display("FAIL ld_cycles: got %0d want 3", load_hi - l0); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_err: got %0b want 0", err); end
      send_word(OP_END);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL ld_done: got %0b want 1", done); end
   endtask

   task automatic test_fetch_timeout();
      pulse_start();
      send_word(OP_FETCH);
      send_word(32'h0000_BEEF);
      send_word(32'd4);
      send_word(32'd0);
      tick();
      tick();
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ft_early_err: got %0b want 0", err); end
      checks++; if (fetch !== 1'b1) begin errors++; $display("FAIL ft_fetch: got %0b want 1", fetch); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ft_err: got %0b want 1", err); end
      checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL ft_err_code: got %0d want 2", err_code); end
      checks++; if (fail_index !== 32'd0) begin errors++; $display("FAIL ft_fail_index: got %0d want 0", fail_index); end
      checks++; if ({fetch, busy} !== 2'b00) begin errors++; $display("FAIL ft_idle: got %b want 00", {fetch, busy}); end
   endtask

   task automatic test_mismatch();
      pulse_start();
      send_word(OP_FETCH);
      send_word(32'h0000_BEEF);
      send_word(32'd4);
      send_word(32'd0);
      odata = 16'hBEEE;
      ack   = 1'b1;
      tick();
      ack   = 1'b0;
      checks++; if (err_code !== 3'd3) begin errors++; $display("FAIL mm_err_code: got %0d want 3", err_code); end
      checks++; if (fail_data !== 16'hBEEE) begin errors++; $display("FAIL mm_fail_data: got %h want beee", fail_data); end
      checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL mm_masked_err: got %0b want 0", m_err); end
      cmd_valid = 1'b1;
      cmd_data  = OP_END;
      tick();
      tick();
      cmd_valid = 1'b0;
      odata     = '0;
      checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL mm_masked_done: got %0b want 1", m_done); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mm_err_ready: got %0b want 0", cmd_ready); end
   endtask

   task automatic test_illegal();
      pulse_start();
      send_word(OP_INIT);
      send_word(OP_CLOCK);
      send_word(32'd7);
      send_word(32'd9);
      checks++; if (err_code !== 3'd4) begin errors++; $display("FAIL il_err_code: got %0d want 4", err_code); end
      checks++; if (fail_index !== 32'd2) begin errors++; $display("FAIL il_fail_index: got %0d want 2", fail_index); end
      cmd_valid = 1'b1;
      cmd_data  = OP_INIT;
      tick();
      tick();
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL il_cmd_ready: got %0b want 0", cmd_ready); end
      checks++; if ({busy, init} !== 2'b00) begin errors++; $display("FAIL il_idle: got %b want 00", {busy, init}); end
      cmd_valid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int lo0;
      pulse_start();
      send_word(OP_LOAD);
      send_word(32'h0000_00A1);
      send_word(32'd8);
      send_word(32'd1);
      lo0 = load_lo;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      checks++; if (load !== 1'b1) begin errors++; $display("FAIL bb_hold: got %0b want 1", load); end
      tick();
      tick();
      tick();
      send_word(OP_LOAD);
      tick();
      send_word(32'h0000_00B2);
      tick();
      send_word(32'd8);
      tick();
      send_word(32'd1);
      checks++; if (idata !== 16'h00B2) begin errors++; $display("FAIL bb_idata: got %h want 00b2", idata); end
      ack = 1'b1;
      @(negedge clk);
      checks++; if (load_lo - lo0 != 0) begin errors++; $display("FAIL bb_load_gap: got %0d low cycles want 0", load_lo - lo0); end
      tick();
      ack = 1'b0;
      send_word(OP_INIT);
      checks++; if ({load, init} !== 2'b01) begin errors++; $display("FAIL bb_init_drop: got %b want 01", {load, init}); end
      send_word(OP_END);
      checks++; if ({done, load} !== 2'b10) begin errors++; $display("FAIL bb_done: got %b want 10", {done, load}); end
   endtask

   task automatic test_async_rst();
      pulse_start();
      send_word(OP_LOAD);
      send_word(32'h0000_5555);
      #2 rst = 1'b1;
      #1;
      checks++; if ({cmd_ready, busy, load, done} !== 4'b0) begin errors++; $display("FAIL ar_ctrl: got %b want 0000", {cmd_ready, busy, load, done}); end
      checks++; if (idata !== 16'd0) begin errors++; $display("FAIL ar_idata: got %h want 0000", idata); end
      checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL ar_cycle_count: got %0d want 0", cycle_count); end
      @(posedge clk);
      #1 rst = 1'b0;
      pulse_start();
      send_word(OP_INIT);
      send_word(OP_END);
      checks++; if ({done, err} !== 2'b10) begin errors++; $display("FAIL ar_rerun: got %b want 10", {done, err}); end
      checks++; if (cycle_count !== 32'd3) begin errors++; $display("FAIL ar_rerun_cycles: got %0d want 3", cycle_count); end
   endtask

   initial begin
      test_reset();
      test_reset_init();
      test_load();
      test_fetch_timeout();
      test_mismatch();
      test_illegal();
      test_back_to_back();
      test_async_rst();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hash_cmd_sequencer.md
# hash_cmd_sequencer

Synthesizable command-stream sequencer that drives a hash core's init/load/fetch/getconfig handshake from a stream of 32-bit command words, in the same command encoding as the team's command files. It sits between a command source (ROM, FIFO or host bridge) and the hash core. It enforces per-command ack timeouts, compares fetched data in hardware, counts cycles and latches the first failure. It replaces bench-only sequencing, so the same command streams run on silicon or FPGA.

## Interface
- IO_W, 16: core data width (idata/odata).
- WORD_W, 32: command word width; also cycle-counter and operand width.
- CMP_MASK, {IO_W{1'b1}}: bit mask applied to both sides of every FETCH/GETCONFIG compare.
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins execution from IDLE, DONE or ERROR.
- cmd_valid  in  1  command word available.
- cmd_data  in  WORD_W  command word (opcode or operand).
- cmd_ready  out  1  word consumed when cmd_valid && cmd_ready.
- core_rst  out  1  active-high reset to hash core.
- init, load, fetch, getconfig  out  1 each  core strobes.
- idata  out  IO_W  load data.
- ack  in  1  core handshake acknowledge.
- odata  in  IO_W  core result.
- busy  out  1  executing.
- done  out  1  END reached with no error (sticky).
- err  out  1  failure (sticky).
- err_code  out  3  0 none, 1 LOAD timeout, 2 FETCH/GETCONFIG timeout, 3 compare mismatch, 4 illegal opcode.
- fail_index  out  WORD_W  0-based index of the failing command.
- fail_data  out  IO_W  odata captured at the mismatch.
- cycle_count  out  WORD_W  cycles since start; saturates at all-ones.

## Operation
- Opcodes (full-word match): 1 RESET n; 2 CLOCK p; 3 INIT; 4 GETCONFIG e t; 5 WAITFOR n; 6 LOAD d t h; 7 FETCH e t h; 0xFFFFFFFF END. Any other value is illegal and gives err_code 4.
- States: IDLE, OPC, ARG, EXEC, DONE, ERROR.
- IDLE/DONE/ERROR -> OPC on start. Start clears done, err, err_code, fail_index, fail_data, cycle_count and the command index.
- OPC: cmd_ready=1. Consumes one word, decodes it, then goes to ARG (operands pending), EXEC (INIT), DONE (END) or ERROR (illegal).
- ARG: cmd_ready=1. Consumes operands in order, then goes to EXEC. CLOCK's operand is consumed and ignored (the clock is external); CLOCK returns to OPC.
- RESET n: core_rst=1 for max(n,1) cycles.
- INIT: init=1 for exactly 1 cycle.
- WAITFOR n: n idle cycles; n=0 returns straight to OPC.
- LOAD: load=1 and idata=d[IO_W-1:0] from the first EXEC cycle. Completes in the first EXEC cycle with ack=1. A wait counter increments each EXEC cycle with ack=0; if it equals t, go to ERROR with err_code 1.
- FETCH/GETCONFIG: same handshake with the fetch/getconfig strobe; timeout gives err_code 2.
  - On ack, compare (odata & CMP_MASK) against (e & CMP_MASK).
  - Mismatch: ERROR, err_code 3, fail_data=odata.
- Hold (h!=0, LOAD/FETCH only): the strobe stays 1 after completion through OPC/ARG. It drops when any command other than the same opcode enters EXEC, or on DONE/ERROR. With h=0 the strobe drops the cycle after the ack cycle.
- Command index increments once per completed opcode word. fail_index is latched on entry to ERROR.
- ERROR and DONE: all strobes 0, core_rst 0, busy 0. Further command words are not consumed.

## Timing
- Reset values: state IDLE, all outputs 0 (including cmd_ready, strobes, core_rst, idata, status, counters).
- Async reset mid-command: immediate return to IDLE; partially consumed operands are discarded.
- Stall in OPC/ARG while cmd_valid=0: hold state. The hold strobe stays asserted; no timeout counts.
- Minimum INIT latency: opcode accepted at cycle k -> init=1 at k+1.
- Minimum LOAD latency: last operand accepted at cycle k -> load=1 at k+1. If ack=1 there, the next opcode can be accepted at k+2.
- busy=1 in OPC, ARG and EXEC.
- cycle_count increments every cycle busy=1.
- done/err assert in the cycle after the deciding event.
- start while busy is ignored.
- ack outside EXEC is ignored.

## Test plan
- RESET 2, INIT, END -> core_rst high exactly 2 cycles, init high 1 cycle, then done=1, err=0, busy=0.
- LOAD 0x1234 t=5 h=0 with ack at the 3rd EXEC cycle -> idata=0x1234 and load=1 for 3 cycles, then load=0; no error.
- FETCH e=0xBEEF t=4, ack never -> err=1, err_code=2, fail_index=0 after 4 ack-free cycles.
- FETCH e=0xBEEF, odata=0xBEEE on ack -> err_code=3, fail_data=0xBEEE. With CMP_MASK=0xFFFE the same stream gives done=1.
- Opcode 0x9 as third command -> err_code=4, fail_index=2, cmd_ready=0 afterwards.
- Two LOAD h=1 back-to-back with cmd_valid gaps -> load never deasserts between them. Async rst mid-ARG -> all outputs 0 immediately.
